// File: rtl/rx_ipv4_if.sv
// IPv4 receive bundle: byte stream in from the Ethernet stage, parsed datagram out.
// slave is the parser side, master is whoever feeds bytes and consumes payload.
// Byte width follows OCT; header fields are fixed by the IPv4 format.
interface rx_ipv4_if #(
   parameter int OCT = 8
);
   logic [31:0]    ip_addr;
   logic           rx_payload_ipv4;
   logic [OCT-1:0] rx_payload;
   logic [31:0]    rx_ipv4_src;
   logic [7:0]     rx_ipv4_protocol;
   logic           rx_ipv4_payload_valid;
   logic [OCT-1:0] rx_ipv4_payload;
   logic           rx_ipv4_done;
   logic           rx_ipv4_err;

   modport master (
      output ip_addr, rx_payload_ipv4, rx_payload,
      input  rx_ipv4_src, rx_ipv4_protocol, rx_ipv4_payload_valid,
             rx_ipv4_payload, rx_ipv4_done, rx_ipv4_err
   );

   modport slave (
      input  ip_addr, rx_payload_ipv4, rx_payload,
      output rx_ipv4_src, rx_ipv4_protocol, rx_ipv4_payload_valid,
             rx_ipv4_payload, rx_ipv4_done, rx_ipv4_err
   );
endinterface

// File: rtl/rx_ipv4.sv
// IPv4 receive parser: validates the header, forwards Total-Length-trimmed payload.
// Latency: payload byte out one cycle after it is sampled; done/err one cycle after the deciding cycle.
// No backpressure: the Ethernet stage streams freely, every qualified byte is consumed.
module rx_ipv4 #(
   parameter int OCT    = 8,
   parameter int IP_VER = 4
) (
   input  logic     RX_CLK,
   input  logic     rst,
   rx_ipv4_if.slave bus
);

   typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, DONE, DRAIN} state_t;

   state_t         state, state_nx;

   logic           vld;
   logic [OCT-1:0] dat;

   // header capture
   logic [5:0]     b;
   logic [3:0]     ver;
   logic [3:0]     ihl;
   logic [15:0]    total_len;
   logic [15:0]    frag;
   logic [7:0]     proto;
   logic [31:0]    src;
   logic [31:0]    dst;
   logic [20:0]    acc;
   logic [OCT-1:0] hi;
   logic [15:0]    rem;

   // registered outputs
   logic [31:0]    src_q;
   logic [7:0]     proto_q;
   logic           pay_vld_q;
   logic [OCT-1:0] pay_q;
   logic           done_q;
   logic           err_q;

   // decision path
   logic [5:0]     hdr_last;
   logic [15:0]    hdr_len;
   logic [31:0]    dst_now;
   logic [20:0]    sum_fin;
   logic [16:0]    fold1;
   logic [15:0]    fold2;
   logic           csum_ok;
   logic           hdr_end;
   logic           accept;
   logic [15:0]    rem_init;

   // FSM side outputs
   logic           pay_stb;
   logic           err_set;
   logic           done_set;

   assign vld = bus.rx_payload_ipv4;
   assign dat = bus.rx_payload;

   assign bus.rx_ipv4_src           = src_q;
   assign bus.rx_ipv4_protocol      = proto_q;
   assign bus.rx_ipv4_payload_valid = pay_vld_q;
   assign bus.rx_ipv4_payload       = pay_q;
   assign bus.rx_ipv4_done          = done_q;
   assign bus.rx_ipv4_err           = err_q;

   // Header-end decision, including the byte sampled this cycle; a bogus IHL below 5 ends at the minimum header.
   always_comb begin
      hdr_last = (ihl < 4'd5) ? 6'd19 : {ihl - 4'd1, 2'b11};
      hdr_len  = {10'd0, ihl, 2'b00};
      dst_now  = (b == 6'd19) ? {dst[23:0], dat} : dst;
      sum_fin  = acc + {5'd0, hi, dat};
      fold1    = {1'b0, sum_fin[15:0]} + {12'd0, sum_fin[20:16]};
      fold2    = fold1[15:0] + {15'd0, fold1[16]};
      csum_ok  = (fold2 == 16'hFFFF);
      hdr_end  = (state == HEADER) && vld && (b == hdr_last);
      accept   = hdr_end
               && (ver == IP_VER[3:0]) && (ihl >= 4'd5)
               && !frag[13] && (frag[12:0] == 13'd0)
               && (dst_now == bus.ip_addr)
               && (total_len >= hdr_len)
               && csum_ok;
      rem_init = total_len - hdr_len;
   end

   // State register.
   always_ff @(posedge RX_CLK) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next state and per-cycle strobes; a drop of the qualifier before completion is a truncation.
   always_comb begin
      state_nx = state;
      pay_stb  = 1'b0;
      err_set  = 1'b0;
      done_set = 1'b0;
      case (state)
         IDLE: begin
            if (vld) state_nx = HEADER;
         end
         HEADER: begin
            if (!vld) begin
               err_set  = 1'b1;
               state_nx = IDLE;
            end else if (hdr_end) begin
               if (!accept) begin
                  err_set  = 1'b1;
                  state_nx = DRAIN;
               end else if (rem_init == 16'd0) begin
                  state_nx = DONE;
               end else begin
                  state_nx = PAYLOAD;
               end
            end
         end
         PAYLOAD: begin
            if (!vld) begin
               err_set  = 1'b1;
               state_nx = IDLE;
            end else begin
               pay_stb = 1'b1;
               if (rem == 16'd1) state_nx = DONE;
            end
         end
         DONE: begin
            done_set = 1'b1;
            state_nx = vld ? DRAIN : IDLE;
         end
         DRAIN: begin
            if (!vld) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Field capture, checksum accumulation, payload countdown and output registers.
   always_ff @(posedge RX_CLK) begin
      if (rst) begin
         b         <= '0;
         ver       <= '0;
         ihl       <= '0;
         total_len <= '0;
         frag      <= '0;
         proto     <= '0;
         src       <= '0;
         dst       <= '0;
         acc       <= '0;
         hi        <= '0;
         rem       <= '0;
         src_q     <= '0;
         proto_q   <= '0;
         pay_vld_q <= 1'b0;
         pay_q     <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         pay_vld_q <= pay_stb;
         done_q    <= done_set;
         err_q     <= err_set;

         if (pay_stb) begin
            pay_q <= dat;
            rem   <= rem - 16'd1;
         end

         if (accept) begin
            src_q   <= src;
            proto_q <= proto;
            rem     <= rem_init;
         end

         case (state)
            IDLE: begin
               acc <= '0;
               b   <= '0;
               if (vld) begin
                  ver <= dat[7:4];
                  ihl <= dat[3:0];
                  hi  <= dat;
                  b   <= 6'd1;
               end
            end
            HEADER: begin
               if (vld) begin
                  b <= b + 6'd1;
                  // even bytes are the high half of a word, odd bytes complete it
                  if (b[0]) acc <= acc + {5'd0, hi, dat};
                  else      hi  <= dat;
                  case (b)
                     6'd2:  total_len[15:8] <= dat;
                     6'd3:  total_len[7:0]  <= dat;
                     6'd6:  frag[15:8]      <= dat;
                     6'd7:  frag[7:0]       <= dat;
                     6'd9:  proto           <= dat;
                     6'd12, 6'd13, 6'd14, 6'd15: src <= {src[23:0], dat};
                     6'd16, 6'd17, 6'd18, 6'd19: dst <= {dst[23:0], dat};
                     default: ;
                  endcase
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rx_ipv4.sv
// Bench for rx_ipv4: directed datagrams plus randomized ones against a frame-level model.
// The model derives payload bytes, pulse cycles and latched fields from the frame bytes alone.
`timescale 1ns/1ps
module tb_rx_ipv4;

   logic RX_CLK = 1'b0;
   logic rst;

   rx_ipv4_if #(.OCT(8)) bus ();

   rx_ipv4 #(.OCT(8), .IP_VER(4)) dut (
      .RX_CLK (RX_CLK),
      .rst    (rst),
      .bus    (bus)
   );

   always #5 RX_CLK = ~RX_CLK;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   logic [31:0] my_ip;
   logic [31:0] exp_src;
   logic [7:0]  exp_proto;
   logic [7:0]  frm[$];

   int          stb_cyc[$];
   logic [7:0]  stb_dat[$];
   int          done_cyc[$];
   int          err_cyc[$];

   always @(posedge RX_CLK) cyc <= cyc + 1;

   // Output monitor, sampled mid-cycle.
   always @(negedge RX_CLK) begin
      if (bus.rx_ipv4_payload_valid) begin
         stb_cyc.push_back(cyc);
         stb_dat.push_back(bus.rx_ipv4_payload);
      end
      if (bus.rx_ipv4_done) done_cyc.push_back(cyc);
      if (bus.rx_ipv4_err)  err_cyc.push_back(cyc);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One's-complement sum of the first hl header bytes, fully folded.
   function automatic int hdr_sum(input int hl);
      int s;
      s = 0;
      for (int k = 0; k < hl; k += 2) s += int'({frm[k], frm[k+1]});
      while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
      return s;
   endfunction

   task automatic build(input logic [3:0] ver, input logic [3:0] ihl, input logic [15:0] tl,
                        input logic [15:0] flags, input logic [7:0] proto, input logic [31:0] src,
                        input logic [31:0] dst, input int n_tail, input logic [7:0] flip);
      int hl;
      int npay;
      logic [15:0] c;
      hl   = int'(ihl) * 4;
      npay = (int'(tl) >= hl) ? int'(tl) - hl : 0;
      frm.delete();
      frm.push_back({ver, ihl});
      frm.push_back(8'h00);
      frm.push_back(tl[15:8]);
      frm.push_back(tl[7:0]);
      frm.push_back(8'($urandom));
      frm.push_back(8'($urandom));
      frm.push_back(flags[15:8]);
      frm.push_back(flags[7:0]);
      frm.push_back(8'h40);
      frm.push_back(proto);
      frm.push_back(8'h00);
      frm.push_back(8'h00);
      for (int k = 3; k >= 0; k--) frm.push_back(src[8*k +: 8]);
      for (int k = 3; k >= 0; k--) frm.push_back(dst[8*k +: 8]);
      for (int k = 20; k < hl; k++) frm.push_back(8'($urandom));
      c = ~16'(hdr_sum(hl));
      frm[10] = c[15:8];
      frm[11] = c[7:0] ^ flip;
      for (int k = 0; k < npay; k++)   frm.push_back(8'($urandom));
      for (int k = 0; k < n_tail; k++) frm.push_back(8'($urandom));
   endtask

   // Drive the first nvalid bytes of frm (reset instead of byte rst_at when rst_at >= 0), then compare.
   task automatic send(input string tag, input int nvalid, input int rst_at);
      int s0, nv, hl, tl, rem, avail, n, exp_done, exp_err;
      bit ok;
      logic [7:0]  b0, b6;
      logic [31:0] dst;
      s0 = 0;
      stb_cyc.delete();
      stb_dat.delete();
      done_cyc.delete();
      err_cyc.delete();
      for (int i = 0; i < nvalid; i++) begin
         @(posedge RX_CLK); #1;
         if (i == 0) s0 = cyc;
         if (i == rst_at) begin
            rst = 1'b1;
            bus.rx_payload_ipv4 = 1'b0;
            break;
         end
         bus.rx_payload_ipv4 = 1'b1;
         bus.rx_payload      = frm[i];
      end
      if (rst_at >= 0) begin
         @(posedge RX_CLK); #1;
         rst = 1'b0;
         @(negedge RX_CLK);
         chk({tag, "_rst_vld"},   32'(bus.rx_ipv4_payload_valid), 32'd0);
         chk({tag, "_rst_pay"},   32'(bus.rx_ipv4_payload), 32'd0);
         chk({tag, "_rst_src"},   bus.rx_ipv4_src, 32'd0);
         chk({tag, "_rst_proto"}, 32'(bus.rx_ipv4_protocol), 32'd0);
         chk({tag, "_rst_done"},  32'(bus.rx_ipv4_done), 32'd0);
         chk({tag, "_rst_err"},   32'(bus.rx_ipv4_err), 32'd0);
      end
      for (int i = 0; i < 6; i++) begin
         @(posedge RX_CLK); #1;
         bus.rx_payload_ipv4 = 1'b0;
         bus.rx_payload      = 8'($urandom);
      end

      // Expected behaviour from the frame bytes.
      nv = (rst_at >= 0) ? rst_at : nvalid;
      b0 = frm[0];
      b6 = frm[6];
      hl = int'(b0[3:0]) * 4;
      tl = int'({frm[2], frm[3]});
      exp_done = -1;
      exp_err  = -1;
      n  = 0;
      if (nv < hl) begin
         if (rst_at < 0) exp_err = s0 + nv + 1;
      end else begin
         dst = {frm[16], frm[17], frm[18], frm[19]};
         ok  = (b0[7:4] == 4'd4) && (b0[3:0] >= 4'd5) && !b6[5]
            && ({b6[4:0], frm[7]} == 13'd0) && (dst == my_ip)
            && (tl >= hl) && (hdr_sum(hl) == 32'hFFFF);
         if (!ok) begin
            exp_err = s0 + hl;
         end else begin
            exp_src   = {frm[12], frm[13], frm[14], frm[15]};
            exp_proto = frm[9];
            rem   = tl - hl;
            avail = nv - hl;
            n     = (avail < rem) ? avail : rem;
            if (rst_at < 0) begin
               if (avail >= rem) exp_done = s0 + hl + rem + 1;
               else              exp_err  = s0 + nv + 1;
            end
         end
      end
      if (rst_at >= 0) begin
         exp_src   = '0;
         exp_proto = '0;
      end

      chk({tag, "_stb_cnt"}, 32'(stb_cyc.size()), 32'(n));
      for (int k = 0; k < n && k < stb_cyc.size(); k++) begin
         chk($sformatf("%s_stb%0d_dat", tag, k), 32'(stb_dat[k]), 32'(frm[hl+k]));
         chk($sformatf("%s_stb%0d_cyc", tag, k), 32'(stb_cyc[k]), 32'(s0 + hl + k + 1));
      end
      chk({tag, "_done_cnt"}, 32'(done_cyc.size()), (exp_done >= 0) ? 32'd1 : 32'd0);
      if (exp_done >= 0 && done_cyc.size() > 0)
         chk({tag, "_done_cyc"}, 32'(done_cyc[0]), 32'(exp_done));
      chk({tag, "_err_cnt"}, 32'(err_cyc.size()), (exp_err >= 0) ? 32'd1 : 32'd0);
      if (exp_err >= 0 && err_cyc.size() > 0)
         chk({tag, "_err_cyc"}, 32'(err_cyc[0]), 32'(exp_err));
      chk({tag, "_src"},   bus.rx_ipv4_src, exp_src);
      chk({tag, "_proto"}, 32'(bus.rx_ipv4_protocol), 32'(exp_proto));
   endtask

   initial begin
      logic [7:0]  tp [20] = '{8'h45, 8'h00, 8'h00, 8'h1C, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
                               8'hB7, 8'h74, 8'hC0, 8'hA8, 8'h01, 8'h0A, 8'hC0, 8'hA8, 8'h01, 8'h02};
      int          kind, ihl, hl, npay, nvalid;
      logic [15:0] tl, flags;
      logic [31:0] dst;
      logic [7:0]  flip;
      logic [3:0]  ver;

      my_ip               = 32'hC0A80102;
      bus.ip_addr         = my_ip;
      bus.rx_payload_ipv4 = 1'b0;
      bus.rx_payload      = 8'h00;
      exp_src             = '0;
      exp_proto           = '0;
      rst                 = 1'b1;
      repeat (3) @(posedge RX_CLK);
      #1 rst = 1'b0;
      @(negedge RX_CLK);
      chk("reset_vld",   32'(bus.rx_ipv4_payload_valid), 32'd0);
      chk("reset_pay",   32'(bus.rx_ipv4_payload), 32'd0);
      chk("reset_src",   bus.rx_ipv4_src, 32'd0);
      chk("reset_proto", 32'(bus.rx_ipv4_protocol), 32'd0);
      chk("reset_done",  32'(bus.rx_ipv4_done), 32'd0);
      chk("reset_err",   32'(bus.rx_ipv4_err), 32'd0);

      // Reference datagram: 8 payload bytes 01..08 then 4 FCS bytes.
      frm.delete();
      for (int k = 0; k < 20; k++) frm.push_back(tp[k]);
      for (int k = 1; k <= 8; k++) frm.push_back(8'(k));
      for (int k = 0; k < 4; k++)  frm.push_back(8'($urandom));
      send("ref", frm.size(), -1);
      chk("ref_src_const",   bus.rx_ipv4_src, 32'hC0A8010A);
      chk("ref_proto_const", 32'(bus.rx_ipv4_protocol), 32'h11);

      // Checksum byte corrupted.
      frm[11] = 8'h75;
      send("badcsum", frm.size(), -1);

      // Wrong destination with a consistent checksum, then a fragment with MF set.
      build(4'd4, 4'd5, 16'd28, 16'h0000, 8'h06, 32'h0A000001, 32'hC0A80103, 4, 8'h00);
      send("baddst", frm.size(), -1);
      build(4'd4, 4'd5, 16'd28, 16'h2000, 8'h06, 32'h0A000002, my_ip, 4, 8'h00);
      send("mf", frm.size(), -1);
      chk("mf_src_kept", bus.rx_ipv4_src, 32'hC0A8010A);

      // Options present: IHL 6, total length 0x20.
      build(4'd4, 4'd6, 16'h0020, 16'h4000, 8'h11, 32'h0A0B0C0D, my_ip, 4, 8'h00);
      send("opts", frm.size(), -1);

      // Truncated after 4 of 8 payload bytes, then a clean datagram.
      build(4'd4, 4'd5, 16'd28, 16'h0000, 8'h11, 32'h01020304, my_ip, 0, 8'h00);
      send("trunc", 24, -1);
      build(4'd4, 4'd5, 16'd28, 16'h0000, 8'h01, 32'h05060708, my_ip, 2, 8'h00);
      send("after_trunc", frm.size(), -1);

      // Reset in the middle of the payload, then a clean datagram.
      build(4'd4, 4'd5, 16'd30, 16'h0000, 8'h11, 32'h11223344, my_ip, 4, 8'h00);
      send("midrst", frm.size(), 23);
      build(4'd4, 4'd5, 16'd26, 16'h0000, 8'h06, 32'h55667788, my_ip, 4, 8'h00);
      send("after_rst", frm.size(), -1);

      // Randomized datagrams across accept and reject causes.
      for (int t = 0; t < 40; t++) begin
         kind  = $urandom_range(0, 9);
         ihl   = $urandom_range(5, 8);
         hl    = ihl * 4;
         npay  = $urandom_range(0, 12);
         tl    = 16'(hl + npay);
         ver   = 4'd4;
         flags = ($urandom_range(0, 1) == 1) ? 16'h4000 : 16'h0000;
         dst   = my_ip;
         flip  = 8'h00;
         case (kind)
            1: flip  = 8'($urandom_range(1, 255));
            2: dst   = my_ip ^ (32'd1 << $urandom_range(0, 31));
            3: flags = 16'h2000;
            4: flags = 16'h4000 | 16'($urandom_range(1, 8191));
            5: ver   = 4'd6;
            6: tl    = 16'($urandom_range(0, hl - 1));
            default: ;
         endcase
         build(ver, 4'(ihl), tl, flags, 8'($urandom), $urandom, dst, $urandom_range(0, 4), flip);
         nvalid = frm.size();
         if (kind == 7) nvalid = $urandom_range(1, hl - 1);
         if (kind == 8 && npay > 0) nvalid = hl + $urandom_range(0, npay - 1);
         send($sformatf("rnd%0d_k%0d", t, kind), nvalid, -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/rx_ipv4.md
Name: rx_ipv4

Overview:
- Consumes the byte stream from the Ethernet receive stage: rx_payload plus the rx_payload_ipv4 qualifier, which is high while bytes of an EtherType 0x0800 frame flow.
- Parses and validates the IPv4 header: version, IHL, fragmentation, destination address and header checksum.
- Latches source address and protocol, and forwards only the IP payload bytes, trimmed by Total Length, to the transport layer.
- Ends each datagram with a done or err pulse.

Parameters:
- OCT, 8, bits per byte.
- IP_VER, 4, required Version field value.

Ports:
- RX_CLK  input  1  receive clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- ip_addr  input  32  local IPv4 address.
- rx_payload_ipv4  input  1  byte-valid from the Ethernet stage; each high cycle carries one byte.
- rx_payload  input  8  byte data.
- rx_ipv4_src  output  32  source IP of the current/last accepted datagram.
- rx_ipv4_protocol  output  8  Protocol field of the current/last accepted datagram.
- rx_ipv4_payload_valid  output  1  payload byte strobe.
- rx_ipv4_payload  output  8  payload byte.
- rx_ipv4_done  output  1  1-cycle pulse: datagram delivered completely.
- rx_ipv4_err  output  1  1-cycle pulse: datagram dropped.

Behaviour:
- Reset: every output is 0, state is IDLE, counters and checksum accumulator are 0. rst mid-datagram aborts with no done/err pulse.
- Byte index b counts from 0 at the first valid byte.
- States:
  - IDLE: first cycle with rx_payload_ipv4=1 is b=0 → HEADER.
  - HEADER: capture fields by byte index.
    - b0: version = [7:4], IHL = [3:0].
    - b2-3: total_len.
    - b6-7: flags/fragment offset.
    - b9: protocol.
    - b12-15: source.
    - b16-19: destination.
    - Bytes b20..IHL*4-1 are options: they are checksummed but discarded.
  - Header end: the decision is made combinationally in the cycle the last header byte (b = IHL*4-1) is sampled. Accept only if all of the following hold:
    - version==IP_VER and IHL>=5;
    - MF==0 and fragment offset==0;
    - destination==ip_addr;
    - total_len >= IHL*4;
    - checksum OK.
  - On accept: latch rx_ipv4_src and rx_ipv4_protocol; load rem = total_len - IHL*4; go to PAYLOAD, or to DONE if rem==0.
  - On reject: pulse err next cycle → DRAIN.
  - PAYLOAD: each valid byte is registered to rx_ipv4_payload with rx_ipv4_payload_valid=1, one cycle latency, and rem is decremented. After the byte that makes rem 0 → DONE.
  - DONE: rx_ipv4_done=1 for exactly one cycle, the cycle after the last payload strobe → DRAIN.
  - DRAIN: ignore bytes (Ethernet padding, FCS) until rx_payload_ipv4=0 → IDLE. A new datagram requires rx_payload_ipv4 to be low for at least one cycle first.
- Truncation: rx_payload_ipv4 falls in HEADER or PAYLOAD before completion → err pulse next cycle → IDLE. No done; partial payload already emitted stays emitted.
- Checksum:
  - Even-index bytes form the high byte and odd-index bytes the low byte of each 16-bit word.
  - Words accumulate into a 21-bit sum (max 30 words).
  - Fold: s = acc[15:0] + acc[20:16], then f = s[15:0] + s[16]. OK iff f == 16'hFFFF.
  - The final word (including the current byte) is included combinationally at the decision cycle.
- done and err are mutually exclusive and never asserted in the same datagram.
- rx_ipv4_payload holds its last value when valid=0.
- rx_ipv4_src and rx_ipv4_protocol change only on accept.

Test Plan:
- Valid datagram: header 45 00 00 1C 00 00 40 00 40 11 B7 74 C0 A8 01 0A C0 A8 01 02, 8 payload bytes 01..08, then 4 FCS bytes; ip_addr=C0A80102 → 8 strobes 01..08, each one cycle after its input; src=C0A8010A, protocol=11; done one cycle after byte 08; no err; FCS not forwarded.
- Same header with checksum byte 74→75 → no payload strobes, err pulse the cycle after b19, return to IDLE after valid falls.
- Destination C0A80103 with corrected checksum, or flags 0x2000 (MF) → err, no strobes; src/protocol keep previous values.
- IHL=6 with 4 option bytes, total_len 0x0020, valid checksum → options skipped; 8 payload bytes forwarded; done.
- rx_payload_ipv4 drops after payload byte 4 of 8 → 4 strobes, then err, no done; the next valid datagram is accepted normally.
- rst asserted mid-PAYLOAD → outputs 0 the next cycle, no pulses; the following datagram is parsed correctly.
